argon_operand_sequencer: RTL

- Upstream controller for the Argon register file bus.
- Accepts one decoded register-register instruction: source indices A/B, destination index C, and an ALU opcode.
- Drives the regfile bus in order: select latch, read A, read B. Presents both operands and the opcode to the ALU, waits for the result, then writes it back through the regfile bus.
- Sits between the decoder and the regfile/ALU pair, and serialises all regfile traffic for data-path instructions.

---
 rtl/argon_operand_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/argon_operand_sequencer.sv
// Operand sequencer: select latch, read A/B from the regfile bus, hand the operands to the ALU, write back.
// Optional ARGON_OPSEQ_UNARY_EN adds i_unary, which skips the B read and forces operand B to zero.
module argon_operand_sequencer #(
  parameter int WORD_W  = 16,
  parameter int INDEX_W = 3,
  parameter int CMD_W   = 4,
  parameter int OP_W    = 5
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
`ifdef ARGON_OPSEQ_UNARY_EN
  input  logic               i_unary,
`endif
  input  logic               i_ins_valid,
  output logic               o_ins_ready,
  input  logic [INDEX_W-1:0] i_idx_a,
  input  logic [INDEX_W-1:0] i_idx_b,
  input  logic [INDEX_W-1:0] i_idx_c,
  input  logic [OP_W-1:0]    i_op,
  output logic               o_rf_valid,
  output logic [CMD_W-1:0]   o_rf_command,
  output logic [WORD_W-1:0]  o_rf_data,
  input  logic               i_rf_valid,
  input  logic [WORD_W-1:0]  i_rf_data,
  output logic               o_ex_valid,
  input  logic               i_ex_ready,
  output logic [WORD_W-1:0]  o_ex_a,
  output logic [WORD_W-1:0]  o_ex_b,
  output logic [OP_W-1:0]    o_ex_op,
  input  logic               i_res_valid,
  input  logic [WORD_W-1:0]  i_res_data,
  output logic               o_busy,
  output logic               o_err
);

  // state | meaning
  // IDLE  | waiting for an instruction, o_ins_ready high
  // SEL   | COM_LATCHSEL with packed {c,b,a} indices
  // RDA   | COM_READA, capture operand A
  // RDB   | COM_READB, capture operand B
  // EXEC  | operands offered to the ALU until i_ex_ready
  // WAIT  | waiting for the ALU result pulse
  // WB    | COM_LATCHC with the result
  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_RDA, S_RDB, S_EXEC, S_WAIT, S_WB
  } state_t;

  localparam logic [CMD_W-1:0] COM_NOP      = CMD_W'(0);
  localparam logic [CMD_W-1:0] COM_LATCHSEL = CMD_W'(1);
  localparam logic [CMD_W-1:0] COM_READA    = CMD_W'(2);
  localparam logic [CMD_W-1:0] COM_READB    = CMD_W'(3);
  localparam logic [CMD_W-1:0] COM_LATCHC   = CMD_W'(4);

  state_t              state_q, state_d;
  logic [INDEX_W-1:0]  idx_a_q, idx_a_d, idx_b_q, idx_b_d, idx_c_q, idx_c_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [WORD_W-1:0]   ex_a_q, ex_a_d, ex_b_q, ex_b_d, res_q, res_d;
  logic                err_q, err_d;
  logic                unary_w;

`ifdef ARGON_OPSEQ_UNARY_EN
  logic unary_q, unary_d;
  assign unary_w = unary_q;
`else
  assign unary_w = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      idx_a_q <= '0;
      idx_b_q <= '0;
      idx_c_q <= '0;
      op_q    <= '0;
      ex_a_q  <= '0;
      ex_b_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef ARGON_OPSEQ_UNARY_EN
      unary_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      idx_c_q <= idx_c_d;
      op_q    <= op_d;
      ex_a_q  <= ex_a_d;
      ex_b_q  <= ex_b_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef ARGON_OPSEQ_UNARY_EN
      unary_q <= unary_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_a_d      = idx_a_q;
    idx_b_d      = idx_b_q;
    idx_c_d      = idx_c_q;
    op_d         = op_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    res_d        = res_q;
    err_d        = err_q;
`ifdef ARGON_OPSEQ_UNARY_EN
    unary_d      = unary_q;
`endif
    o_ins_ready  = 1'b0;
    o_rf_valid   = 1'b0;
    o_rf_command = COM_NOP;
    o_rf_data    = '0;
    o_ex_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_ins_ready = 1'b1;
        if (i_ins_valid) begin
          idx_a_d = i_idx_a;
          idx_b_d = i_idx_b;
          idx_c_d = i_idx_c;
          op_d    = i_op;
`ifdef ARGON_OPSEQ_UNARY_EN
          unary_d = i_unary;
`endif
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        o_rf_valid   = 1'b1;
        o_rf_command = COM_LATCHSEL;
        o_rf_data    = {{(WORD_W-3*INDEX_W){1'b0}}, idx_c_q, idx_b_q, idx_a_q};
        state_d      = S_RDA;
      end
      S_RDA: begin
        o_rf_command = COM_READA;
        ex_a_d       = i_rf_valid ? i_rf_data : '0;
        err_d        = err_q | ~i_rf_valid;
        if (unary_w) begin
          ex_b_d  = '0;
          state_d = S_EXEC;
        end else begin
          state_d = S_RDB;
        end
      end
      S_RDB: begin
        o_rf_command = COM_READB;
        ex_b_d       = i_rf_valid ? i_rf_data : '0;
        err_d        = err_q | ~i_rf_valid;
        state_d      = S_EXEC;
      end
      S_EXEC: begin
        o_ex_valid = 1'b1;
        if (i_ex_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_res_valid) begin
          res_d   = i_res_data;
          state_d = S_WB;
        end
      end
      S_WB: begin
        // Issued even for idx_c == 0; the regfile drops writes to r0.
        o_rf_valid   = 1'b1;
        o_rf_command = COM_LATCHC;
        o_rf_data    = res_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ex_a  = ex_a_q;
  assign o_ex_b  = ex_b_q;
  assign o_ex_op = op_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_err   = err_q;

endmodule
